// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - parallel-side handshake bundle for the UART transmitter
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);

  // Word to send, request strobe and per-frame parity options
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;

  // High from accept until the end of the stop bit
  logic                  busy;

  // System-side register/FIFO logic drives the request
  modport master (
    output P_DATA,
    output Data_Valid,
    output PAR_EN,
    output PAR_TYP,
    input  busy
  );

  // The transmitter consumes the request and reports busy
  modport slave (
    input  P_DATA,
    input  Data_Valid,
    input  PAR_EN,
    input  PAR_TYP,
    output busy
  );

endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, LSB-first data, optional parity, one stop bit
module uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic      CLK,
  input  logic      RST,
  uart_tx_if.slave  host,
  output logic      TX_OUT
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  logic                  bit_done;
  logic                  last_bit;
  logic                  accept;

  // A bit period ends on the last baud count; last_bit marks the MSB slot
  assign bit_done = (cnt_q == CNT_LAST);
  assign last_bit = (idx_q == IDX_LAST);
  assign accept   = (state_q == IDLE) && host.Data_Valid;

  // State and datapath registers; reset abandons any frame in progress
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  // Frame sequencing: each non-idle state advances when its bit period ends
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (host.Data_Valid) state_d = START;
      START:   if (bit_done) state_d = DATA;
      DATA:    if (bit_done && last_bit) state_d = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_done) state_d = STOP;
      STOP:    if (bit_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for counters, shift register and the registered line/busy outputs
  always_comb begin
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;

    if (state_q == IDLE) begin
      cnt_d = '0;
      idx_d = '0;
      if (accept) begin
        // Options are captured here so later input changes cannot disturb the frame
        shift_d   = host.P_DATA;
        par_en_d  = host.PAR_EN;
        par_bit_d = (^host.P_DATA) ^ host.PAR_TYP;
      end
    end else begin
      cnt_d = bit_done ? '0 : cnt_q + CNT_W'(1);
      if ((state_q == START) && bit_done) begin
        idx_d = '0;
      end
      if ((state_q == DATA) && bit_done && !last_bit) begin
        idx_d   = idx_q + IDX_W'(1);
        shift_d = shift_q >> 1;
      end
    end

    // Line level is derived from the state being entered so it changes exactly on the edge
    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_bit_d;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign TX_OUT    = tx_q;
  assign host.busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed scoreboard bench for uart_tx
module tb_uart_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;

  logic CLK = 1'b0;
  logic RST;
  logic TX_OUT;

  uart_tx_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .host  (bus),
    .TX_OUT(TX_OUT)
  );

  always #5 CLK = ~CLK;

  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];
  int   bc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [DW-1:0] d, input logic pen, input logic ptyp);
    bus.P_DATA     = d;
    bus.PAR_EN     = pen;
    bus.PAR_TYP    = ptyp;
    bus.Data_Valid = 1'b1;
  endtask

  task automatic push_frame(input logic [DW-1:0] d, input logic pen, input logic ptyp);
    int ones;
    ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < DW; i++) begin
      exp_q.push_back(d[i]);
      if (d[i]) ones++;
    end
    if (pen) exp_q.push_back(((ones % 2) == 1) ^ ptyp);
    exp_q.push_back(1'b1);
  endtask

  task automatic run_frame(input string tag, input int max_cyc, input int glitch_cyc,
                           output int busy_cycles);
    int   cyc;
    logic b;
    cyc = 0;
    busy_cycles = 0;
    while (exp_q.size() > 0 && cyc < max_cyc) begin
      b = exp_q.pop_front();
      for (int c = 0; c < CPB && cyc < max_cyc; c++) begin
        chk({tag, " tx"}, TX_OUT, b);
        chk({tag, " busy"}, bus.busy, 1);
        if (bus.busy === 1'b1) busy_cycles++;
        if (glitch_cyc >= 0 && cyc == glitch_cyc) drive(8'hFF, 1'b1, 1'b1);
        else if (glitch_cyc >= 0 && cyc == glitch_cyc + 1) bus.Data_Valid = 1'b0;
        tick;
        cyc++;
      end
    end
  endtask

  task automatic check_idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, " tx"}, TX_OUT, 1);
      chk({tag, " busy"}, bus.busy, 0);
      tick;
    end
  endtask

  initial begin
    RST            = 1'b1;
    bus.Data_Valid = 1'b0;
    bus.P_DATA     = '0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;

    tick;
    chk("reset1 tx", TX_OUT, 1);
    chk("reset1 busy", bus.busy, 0);
    tick;
    chk("reset2 tx", TX_OUT, 1);
    chk("reset2 busy", bus.busy, 0);
    RST = 1'b0;
    check_idle("idle", 3);

    drive(8'hA5, 1'b0, 1'b0);
    push_frame(8'hA5, 1'b0, 1'b0);
    tick;
    bus.Data_Valid = 1'b0;
    run_frame("a5_nopar", 1000, -1, bc);
    chk("a5_nopar busy_len", bc, 40);
    check_idle("a5_nopar end", 2);

    drive(8'hA5, 1'b1, 1'b0);
    push_frame(8'hA5, 1'b1, 1'b0);
    tick;
    bus.Data_Valid = 1'b0;
    run_frame("a5_even", 1000, -1, bc);
    chk("a5_even busy_len", bc, 44);
    check_idle("a5_even end", 2);

    drive(8'hA5, 1'b1, 1'b1);
    push_frame(8'hA5, 1'b1, 1'b1);
    tick;
    bus.Data_Valid = 1'b0;
    run_frame("a5_odd", 1000, -1, bc);
    chk("a5_odd busy_len", bc, 44);
    check_idle("a5_odd end", 2);

    drive(8'h07, 1'b1, 1'b0);
    push_frame(8'h07, 1'b1, 1'b0);
    tick;
    bus.Data_Valid = 1'b0;
    run_frame("07_even", 1000, -1, bc);
    chk("07_even busy_len", bc, 44);
    check_idle("07_even end", 2);

    drive(8'h00, 1'b0, 1'b0);
    push_frame(8'h00, 1'b0, 1'b0);
    tick;
    bus.Data_Valid = 1'b0;
    run_frame("ignore", 1000, 13, bc);
    chk("ignore busy_len", bc, 40);
    check_idle("ignore no_second", 50);

    drive(8'h3C, 1'b0, 1'b0);
    push_frame(8'h3C, 1'b0, 1'b0);
    tick;
    bus.P_DATA = 8'hC3;
    run_frame("b2b_first", 1000, -1, bc);
    chk("b2b_first busy_len", bc, 40);
    push_frame(8'hC3, 1'b0, 1'b0);
    check_idle("b2b gap", 1);
    bus.Data_Valid = 1'b0;
    run_frame("b2b_second", 1000, -1, bc);
    chk("b2b_second busy_len", bc, 40);
    check_idle("b2b end", 3);

    drive(8'h00, 1'b0, 1'b0);
    push_frame(8'h00, 1'b0, 1'b0);
    tick;
    bus.Data_Valid = 1'b0;
    run_frame("midreset pre", 18, -1, bc);
    exp_q.delete();
    RST = 1'b1;
    drive(8'h5A, 1'b1, 1'b1);
    tick;
    chk("midreset tx", TX_OUT, 1);
    chk("midreset busy", bus.busy, 0);
    RST = 1'b0;
    push_frame(8'h5A, 1'b1, 1'b1);
    tick;
    bus.Data_Valid = 1'b0;
    run_frame("post_reset", 1000, -1, bc);
    chk("post_reset busy_len", bc, 44);
    check_idle("post_reset end", 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
